// File: rtl/bus_dma_ctrl_pkg.sv
// bus_dma_ctrl shared types and defaults.
// FSM encoding and bus geometry used by the DMA core and its bus interface.
package bus_dma_ctrl_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 64;
  localparam int BURST_MAX_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RD     = 3'd2,
    S_RD_CAP = 3'd3,
    S_WR     = 3'd4,
    S_YIELD  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/bus_dma_ctrl_if.sv
// Shared-bus master port: req/grant handshake plus read/write transfer.
// The DMA drives the master side; the arbiter/memory model drives the slave side.
interface bus_dma_ctrl_if #(
  parameter int ADDR_W = bus_dma_ctrl_pkg::ADDR_W_DEF,
  parameter int DATA_W = bus_dma_ctrl_pkg::DATA_W_DEF
);

  logic              m_req;
  logic              m_grant;
  logic              m_wr;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req,
    output m_wr,
    output m_address,
    output m_dout,
    input  m_grant,
    input  m_din
  );

  modport slave (
    input  m_req,
    input  m_wr,
    input  m_address,
    input  m_dout,
    output m_grant,
    output m_din
  );

endinterface

// File: rtl/bus_dma_cnt.sv
// Address/count datapath for the DMA: source, destination, remaining words
// and per-tenure burst counter, with last-word and burst-end flags.
module bus_dma_cnt
  import bus_dma_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              clr_burst_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [7:0]        len_i,
  output logic [ADDR_W-1:0] src_nxt_o,
  output logic [ADDR_W-1:0] dst_nxt_o,
  output logic              last_o,
  output logic              burst_end_o
);

  localparam int BW = $clog2(BURST_MAX + 1);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [7:0]        remain_q, remain_d;
  logic [BW-1:0]     burst_q, burst_d;

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    burst_d  = burst_q;
    if (load_i) begin
      src_d    = src_i;
      dst_d    = dst_i;
      remain_d = len_i;
      burst_d  = '0;
    end else begin
      if (step_i) begin
        src_d    = src_q + ADDR_W'(1);
        dst_d    = dst_q + ADDR_W'(1);
        remain_d = remain_q - 8'd1;
        burst_d  = burst_q + BW'(1);
      end
      if (clr_burst_i) begin
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      burst_q  <= '0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      burst_q  <= burst_d;
    end
  end

  // Next values let the FSM register the bus address in the same cycle.
  assign src_nxt_o   = src_d;
  assign dst_nxt_o   = dst_d;
  assign last_o      = (remain_q == 8'd1);
  assign burst_end_o = (burst_q == BW'(BURST_MAX - 1));

endmodule

// File: rtl/bus_dma_ctrl.sv
// Single-channel DMA: copies len words src->dst as read/write pairs on the
// shared bus, dropping request for one cycle after every BURST_MAX words.
module bus_dma_ctrl
  import bus_dma_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        len,
  output logic              busy,
  output logic              done,
  bus_dma_ctrl_if.master    bus
);

  state_e state_q, state_d;

  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_dout_q, m_dout_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req;

  logic              load;
  logic              step;
  logic              clr_burst;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic              last;
  logic              burst_end;

  assign load      = (state_q == S_IDLE) && start && (len != 8'd0);
  assign step      = (state_q == S_WR) && bus.m_grant;
  assign clr_burst = (state_q == S_YIELD);

  bus_dma_cnt #(
    .ADDR_W   (ADDR_W),
    .BURST_MAX(BURST_MAX)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .step_i     (step),
    .clr_burst_i(clr_burst),
    .src_i      (src_addr),
    .dst_i      (dst_addr),
    .len_i      (len),
    .src_nxt_o  (src_nxt),
    .dst_nxt_o  (dst_nxt),
    .last_o     (last),
    .burst_end_o(burst_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_dout_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      m_wr_q   <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_dout_q <= m_dout_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len != 8'd0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (bus.m_grant) state_d = S_RD;
      end
      S_RD: begin
        if (bus.m_grant) state_d = S_RD_CAP;
      end
      S_RD_CAP: state_d = S_WR;
      S_WR: begin
        if (bus.m_grant) begin
          if (last)           state_d = S_DONE;
          else if (burst_end) state_d = S_YIELD;
          else                state_d = S_RD;
        end
      end
      S_YIELD: state_d = S_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req  = (state_q == S_REQ) || (state_q == S_RD) ||
           (state_q == S_RD_CAP) || (state_q == S_WR);
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    // Read data is valid the cycle after the granted read, grant or not.
    data_d   = (state_q == S_RD_CAP) ? bus.m_din : data_q;
    m_wr_d   = (state_d == S_WR);
    m_addr_d = m_addr_q;
    m_dout_d = m_dout_q;
    unique case (1'b1)
      (state_d == S_RD): m_addr_d = src_nxt;
      (state_d == S_WR): begin
        m_addr_d = dst_nxt;
        m_dout_d = data_d;
      end
      default: ;
    endcase
  end

  assign bus.m_req     = req;
  assign bus.m_wr      = m_wr_q;
  assign bus.m_address = m_addr_q;
  assign bus.m_dout    = m_dout_q;

endmodule

// File: doc/bus_dma_ctrl.md
Name: bus_dma_ctrl

Overview:
Single-channel DMA controller acting as a bus master on the two-master shared bus. It copies LEN 64-bit words from a source address range to a destination address range. Each word is one read transfer followed by one write transfer, issued through the bus req/grant handshake. To stay fair to the other master, it releases the bus after a bounded burst of words.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 64, bus data width
BURST_MAX, 4, words moved per bus tenure before a forced one-cycle release (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; launches a copy when idle
src_addr  input  ADDR_W  first source address, sampled on accepted start
dst_addr  input  ADDR_W  first destination address, sampled on accepted start
len  input  8  word count, sampled on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the copy completes
m_req  output  1  bus request to arbiter
m_grant  input  1  bus grant from arbiter
m_wr  output  1  1 = write transfer, 0 = read transfer
m_address  output  ADDR_W  transfer address
m_dout  output  DATA_W  write data to bus
m_din  input  DATA_W  read data from bus, valid one cycle after the granted read cycle

Behaviour:
- Reset (sync, active-high): state=IDLE; m_req=0, m_wr=0, m_address=0, m_dout=0, busy=0, done=0.
  - All counters and the data buffer clear.
  - A reset mid-copy abandons the copy. m_req is low after that edge. No done pulse.
- Transfer rule: a bus cycle is consumed only when m_grant=1 in a cycle where m_req=1 and the FSM is in RD or WR. Otherwise the FSM holds, with address and data stable.
- FSM states: IDLE, REQ, RD, RD_CAP, WR, YIELD, DONE.
  - IDLE: start=1 and len!=0 -> latch src/dst/len into cur_src, cur_dst, remain; burst_cnt=0 -> REQ.
  - IDLE: start=1 and len=0 -> DONE. No bus activity.
  - REQ: m_req=1 -> RD when m_grant=1.
  - RD: m_req=1, m_wr=0, m_address=cur_src.
    - If m_grant=1 -> RD_CAP.
    - If m_grant=0 -> stay.
  - RD_CAP: m_req=1 (bus retained). Capture m_din into buf. -> WR unconditionally.
  - WR: m_req=1, m_wr=1, m_address=cur_dst, m_dout=buf.
    - If m_grant=1: cur_src++, cur_dst++ (mod 2^ADDR_W, wrap 0xFF->0x00); remain--; burst_cnt++.
    - Then: remain==1 (last word) -> DONE; else if burst_cnt==BURST_MAX-1 -> YIELD; else -> RD.
    - If m_grant=0 -> stay.
  - YIELD: m_req=0 for exactly one cycle; burst_cnt=0 -> REQ.
  - DONE: done=1 for one cycle; m_req=0 -> IDLE.
- busy: 1 in every state except IDLE. busy drops in the cycle after the DONE cycle.
- m_wr, m_address, m_dout are registered outputs. In IDLE, REQ, YIELD and DONE: m_wr=0, m_address holds its last value, m_dout holds its last value.
- start while busy is ignored. Sampled inputs changing while busy have no effect.
- Grant loss between RD and RD_CAP does not corrupt the data: capture is unconditional one cycle after the granted read.
- Latency, len=1, grant always 1: start@c0, REQ c1, RD c2, RD_CAP c3, WR c4, DONE c5 (done=1).
- Per word with no contention: 3 cycles (RD, RD_CAP, WR). Plus 2 cycles (YIELD, REQ) every BURST_MAX words.

Decomposition:
- Shared package: FSM state encoding constants, ADDR_W/DATA_W defaults.
- One natural sub-module: bus_dma_cnt. It holds the address/count datapath: cur_src, cur_dst, remain and burst_cnt registers with load/increment/decrement and the last-word and burst-end flags. The FSM stays in bus_dma_ctrl.

Test Plan:
- Reset mid-copy: assert reset during WR of word 2 of len=4 -> next cycle m_req=0, busy=0, all outputs 0; no done pulse; a new start then works normally.
- Basic copy, grant tied 1: src=0x10, dst=0x80, len=1, memory[0x10]=64'hDEAD_BEEF -> write at 0x80 with m_dout=64'hDEAD_BEEF at c4; done at c5.
- Burst/yield, BURST_MAX=4, len=6, grant tied 1 -> reads 0x10..0x15, writes 0x80..0x85 in order; one m_req=0 cycle after the 4th write; single done; total 22 cycles from start to done.
- Wrap and zero length: src=0xFE, dst=0xFF, len=3 -> reads 0xFE,0xFF,0x00 and writes 0xFF,0x00,0x01. Separately, len=0 -> done one cycle after start; m_req never asserted.
- Contention: m_grant=0 for 5 cycles while in RD, and later while in WR -> FSM holds with m_address stable; no address or count advance; data written matches data read; start pulses during busy ignored.
